// File: rtl/uart_receiver.sv
// UART receive end: 16x oversampled 8E1 frame recovery with per-frame parity/framing flags.
// Optional RX_MAJORITY_EN: 3-sample majority vote at ticks 6/7/8, decision moves to tick 8.
module uart_receiver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVS    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_ENABLE,
  input  logic              Rx_EN,
  input  logic              RxD,
  output logic [DATA_W-1:0] Rx_DATA,
  output logic              Rx_VALID,
  output logic              Rx_PERROR,
  output logic              Rx_FERROR
);

  localparam int unsigned CNT_W = $clog2(OVS);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

`ifdef RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] DEC_TICK = CNT_W'(8);
`else
  localparam logic [CNT_W-1:0] DEC_TICK = CNT_W'(7);
`endif
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

  logic              rxd_m, rxd_s;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              perr_pend_q, perr_pend_d;
  logic              idle_high_q, idle_high_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              bit_smp;
  logic              dec_tick, wrap_tick;

`ifdef RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (sample_ENABLE && cnt_q == CNT_W'(6)) vote_d[0] = rxd_s;
    if (sample_ENABLE && cnt_q == CNT_W'(7)) vote_d[1] = rxd_s;
  end

  assign bit_smp = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);
`else
  assign bit_smp = rxd_s;
`endif

  assign dec_tick  = sample_ENABLE && (cnt_q == DEC_TICK);
  assign wrap_tick = sample_ENABLE && (cnt_q == LAST_TICK);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    perr_pend_d = perr_pend_q;
    idle_high_d = idle_high_q | ((state_q == S_IDLE) & rxd_s);
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    if (sample_ENABLE) cnt_d = cnt_q + CNT_W'(1);

    if (!Rx_EN) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          // A start needs a prior high level so a held-low line cannot retrigger
          if (sample_ENABLE && !rxd_s && idle_high_q) begin
            state_d     = S_START;
            cnt_d       = CNT_W'(1);
            perr_d      = 1'b0;
            ferr_d      = 1'b0;
            idle_high_d = 1'b0;
          end
        end
        S_START: begin
          if (dec_tick && bit_smp) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (wrap_tick) begin
            state_d = S_DATA;
            idx_d   = '0;
            par_d   = 1'b0;
          end
        end
        S_DATA: begin
          if (dec_tick) begin
            shift_d = {bit_smp, shift_q[DATA_W-1:1]};
            par_d   = par_q ^ bit_smp;
          end
          if (wrap_tick) begin
            if (idx_q == LAST_IDX) state_d = S_PARITY;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
        end
        S_PARITY: begin
          if (dec_tick)  perr_pend_d = bit_smp ^ par_q;
          if (wrap_tick) state_d     = S_STOP;
        end
        S_STOP: begin
          // Leave at mid-stop so the next start edge is caught without slip
          if (dec_tick) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            perr_d  = perr_pend_q;
            ferr_d  = ~bit_smp;
            if (bit_smp && !perr_pend_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m       <= 1'b1;
      rxd_s       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      perr_pend_q <= 1'b0;
      idle_high_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef RX_MAJORITY_EN
      vote_q      <= 2'b11;
`endif
    end else begin
      rxd_m       <= RxD;
      rxd_s       <= rxd_m;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      perr_pend_q <= perr_pend_d;
      idle_high_q <= idle_high_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
`ifdef RX_MAJORITY_EN
      vote_q      <= vote_d;
`endif
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of 8E1 frames plus hand-built corner sequences.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_ENABLE = 1'b0;
  logic       Rx_EN = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int n_pass  = 0;
  int n_total = 0;

  uart_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .sample_ENABLE(sample_ENABLE),
    .Rx_EN        (Rx_EN),
    .RxD          (RxD),
    .Rx_DATA      (Rx_DATA),
    .Rx_VALID     (Rx_VALID),
    .Rx_PERROR    (Rx_PERROR),
    .Rx_FERROR    (Rx_FERROR)
  );

  initial forever #5 clk = ~clk;

  // Sample strobe every 4 clk, changed on the falling edge
  logic [1:0] div = 2'd0;
  always @(negedge clk) begin
    div = div + 2'd1;
    sample_ENABLE = (div == 2'd0);
  end

  // Count every high cycle of Rx_VALID and remember the last two bytes delivered
  int         pulses = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (Rx_VALID) begin
      pulses    = pulses + 1;
      prev_data = last_data;
      last_data = Rx_DATA;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sample_ENABLE) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input int nticks);
    #1 RxD = b;
    wait_ticks(nticks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(par, 16);
    send_bit(stop, 16);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         exp_pulses;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int   p0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 0, 8'h55, 1'b1, 1'b1};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1, 8'h07, 1'b0, 1'b0};

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_data",  32'(Rx_DATA),   32'h00);
    check("rst_valid", 32'(Rx_VALID),  32'h0);
    check("rst_perr",  32'(Rx_PERROR), 32'h0);
    check("rst_ferr",  32'(Rx_FERROR), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    send_bit(1'b1, 8);

    for (int i = 0; i < 6; i++) begin
      p0 = pulses;
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop);
      send_bit(1'b1, 8);
      @(negedge clk);
      check($sformatf("v%0d_pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
      check($sformatf("v%0d_data", i),   32'(Rx_DATA),     32'(vecs[i].exp_data));
      check($sformatf("v%0d_perr", i),   32'(Rx_PERROR),   32'(vecs[i].exp_perr));
      check($sformatf("v%0d_ferr", i),   32'(Rx_FERROR),   32'(vecs[i].exp_ferr));
    end

    // Short low glitch while idle: false start, nothing reported
    p0 = pulses;
    send_bit(1'b0, 4);
    send_bit(1'b1, 24);
    @(negedge clk);
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    check("glitch_data",   32'(Rx_DATA),     32'h07);
    check("glitch_perr",   32'(Rx_PERROR),   32'h0);
    check("glitch_ferr",   32'(Rx_FERROR),   32'h0);

    // Back-to-back frames with no idle gap
    p0 = pulses;
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    send_bit(1'b1, 8);
    @(negedge clk);
    check("b2b_pulses", 32'(pulses - p0), 32'd2);
    check("b2b_first",  32'(prev_data),   32'h12);
    check("b2b_second", 32'(last_data),   32'h34);

    // Receiver disabled after three data bits, then a clean frame
    p0 = pulses;
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 16);
    #1 Rx_EN = 1'b0;
    RxD = 1'b1;
    wait_ticks(200);
    @(negedge clk);
    check("en_drop_pulses", 32'(pulses - p0), 32'd0);
    check("en_drop_data",   32'(Rx_DATA),     32'h34);
    #1 Rx_EN = 1'b1;
    wait_ticks(4);
    send_frame(8'h7E, 1'b0, 1'b1);
    send_bit(1'b1, 8);
    @(negedge clk);
    check("en_7e_pulses", 32'(pulses - p0), 32'd1);
    check("en_7e_data",   32'(Rx_DATA),     32'h7E);
    check("en_7e_last",   32'(last_data),   32'h7E);

    // Break: line held low keeps the framing error and never restarts
    p0 = pulses;
    send_frame(8'h00, 1'b0, 1'b0);
    send_bit(1'b0, 48);
    @(negedge clk);
    check("break_pulses", 32'(pulses - p0), 32'd0);
    check("break_ferr",   32'(Rx_FERROR),   32'h1);
    check("break_data",   32'(Rx_DATA),     32'h7E);
    send_bit(1'b1, 8);
    send_frame(8'h55, 1'b0, 1'b1);
    send_bit(1'b1, 8);
    @(negedge clk);
    check("after_break_pulses", 32'(pulses - p0), 32'd1);
    check("after_break_data",   32'(Rx_DATA),     32'h55);
    check("after_break_ferr",   32'(Rx_FERROR),   32'h0);

    // Reset pulsed in the middle of a frame
    send_frame(8'h01, 1'b0, 1'b1);
    send_bit(1'b1, 8);
    @(negedge clk);
    check("pre_rst_perr", 32'(Rx_PERROR), 32'h1);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_data",  32'(Rx_DATA),   32'h00);
    check("mid_rst_valid", 32'(Rx_VALID),  32'h0);
    check("mid_rst_perr",  32'(Rx_PERROR), 32'h0);
    check("mid_rst_ferr",  32'(Rx_FERROR), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    p0 = pulses;
    send_bit(1'b1, 8);
    send_frame(8'hC3, 1'b0, 1'b1);
    send_bit(1'b1, 8);
    @(negedge clk);
    check("post_rst_pulses", 32'(pulses - p0), 32'd1);
    check("post_rst_data",   32'(Rx_DATA),     32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
